// File: rtl/iter_alu_unit.sv
// Multi-cycle execute unit: single-cycle ADD/SUB/AND/OR plus iterative
// shift-add multiply and restoring unsigned divide/remainder.
module iter_alu_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             Zero_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   data_q;
    logic               zero_q;

    logic               accept;
    logic               is_iter;
    logic               last;
    logic [WIDTH-1:0]   simple_res;
    logic [WIDTH-1:0]   mul_acc;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic               q_bit;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   div_quo;
    logic [WIDTH-1:0]   a_nxt;
    logic [WIDTH-1:0]   b_nxt;
    logic [WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]   iter_res;

    assign accept  = (state == IDLE) && start_i;
    assign is_iter = ALUCtrl_i[2] && (ALUCtrl_i[1] || ALUCtrl_i[0]);
    assign last    = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        simple_res = '0;
        case (ALUCtrl_i)
            3'b000:  simple_res = data1_i + data2_i;
            3'b001:  simple_res = data1_i - data2_i;
            3'b010:  simple_res = data1_i & data2_i;
            3'b011:  simple_res = data1_i | data2_i;
            default: simple_res = '0;
        endcase
    end

    // Divide: a_q shifts the dividend out MSB-first and collects quotient bits.
    assign mul_acc = b_q[0] ? (acc_q + a_q) : acc_q;
    assign rem_sh  = {acc_q, a_q[WIDTH-1]};
    assign diff    = rem_sh - {1'b0, b_q};
    assign q_bit   = ~diff[WIDTH];
    assign div_rem = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign div_quo = {a_q[WIDTH-2:0], q_bit};

    always_comb begin
        acc_nxt  = div_rem;
        a_nxt    = div_quo;
        b_nxt    = b_q;
        iter_res = div_quo;
        case (op_q)
            3'b101: begin
                acc_nxt  = mul_acc;
                a_nxt    = a_q << 1;
                b_nxt    = b_q >> 1;
                iter_res = mul_acc;
            end
            3'b111:  iter_res = div_rem;
            default: iter_res = div_quo;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_i) state_nxt = is_iter ? RUN : DONE;
            RUN:  if (last)    state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state != IDLE);
        valid_o = (state == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            data_q <= '0;
            zero_q <= 1'b0;
        end else if (accept) begin
            op_q  <= ALUCtrl_i;
            a_q   <= data1_i;
            b_q   <= data2_i;
            acc_q <= '0;
            cnt_q <= '0;
            if (!is_iter) begin
                data_q <= simple_res;
                zero_q <= (simple_res == '0);
            end
        end else if (state == RUN) begin
            a_q   <= a_nxt;
            b_q   <= b_nxt;
            acc_q <= acc_nxt;
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
                data_q <= iter_res;
                zero_q <= (iter_res == '0);
            end
        end
    end

    assign data_o = data_q;
    assign Zero_o = zero_q;

endmodule

// File: tb/tb_iter_alu_unit.sv
// Self-checking bench for iter_alu_unit: scoreboard of expected results,
// latency, handshake and reset-abort checks.
module tb_iter_alu_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] d1 = '0;
    logic [W-1:0] d2 = '0;
    logic         busy;
    logic         valid;
    logic [W-1:0] dout;
    logic         zero;

    typedef struct {
        logic [W-1:0] data;
        logic         zero;
        int           lat;
        string        name;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail = 0;

    iter_alu_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .ALUCtrl_i(op),
        .data1_i  (d1),
        .data2_i  (d2),
        .busy_o   (busy),
        .valid_o  (valid),
        .data_o   (dout),
        .Zero_o   (zero)
    );

    always #5 clk = ~clk;

    function automatic void push_exp(input string nm, input logic [W-1:0] e,
                                     input int lat);
        exp_t x;
        x.data = e;
        x.zero = (e == '0);
        x.lat  = lat;
        x.name = nm;
        sb.push_back(x);
    endfunction

    // Wait for IDLE, present one request for one edge, then scramble inputs.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        op = o;
        d1 = a;
        d2 = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 3'($urandom);
        d1 = $urandom;
        d2 = $urandom;
    endtask

    task automatic await_valid(output int lat, output bit to);
        lat = 0;
        to = 1'b0;
        forever begin
            @(negedge clk);
            lat++;
            if (valid) break;
            if (lat >= 100) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_table(input logic [2:0] ops[], input logic [W-1:0] as[],
                             input logic [W-1:0] bs[]);
        int lat;
        bit to;
        exp_t e;
        foreach (ops[i]) begin
            issue(ops[i], as[i], bs[i]);
            await_valid(lat, to);
            e = sb.pop_front();
            n_checks++;
            if (to || dout !== e.data || zero !== e.zero || lat != e.lat) begin
                n_fail++;
                $display("FAIL %s: got data=%h zero=%b lat=%0d to=%0b, need data=%h zero=%b lat=%0d",
                         e.name, dout, zero, lat, to, e.data, e.zero, e.lat);
            end
            @(negedge clk);
            n_checks++;
            if (valid !== 1'b0 || dout !== e.data) begin
                n_fail++;
                $display("FAIL %s_pulse: got valid=%b data=%h, need valid=0 data=%h",
                         e.name, valid, dout, e.data);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || dout !== '0 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b valid=%b data=%h zero=%b, need 0 0 0 0",
                     busy, valid, dout, zero);
        end
        rst = 1'b1;
    endtask

    task automatic test_reset_mid_mul();
        int pulses = 0;
        int lat;
        bit to;
        exp_t e;
        issue(3'b101, 32'd7, 32'd6);
        repeat (9) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_busy_before_rst: got busy=%b, need 1", busy);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || dout !== '0 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_mul: got busy=%b valid=%b data=%h zero=%b, need 0 0 0 0",
                     busy, valid, dout, zero);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        n_checks++;
        if (pulses != 0 || dout !== '0) begin
            n_fail++;
            $display("FAIL rst_abort: got pulses=%0d data=%h, need 0 and 0", pulses, dout);
        end
        push_exp("add_after_rst", 32'd8, 1);
        issue(3'b000, 32'd5, 32'd3);
        await_valid(lat, to);
        e = sb.pop_front();
        n_checks++;
        if (to || dout !== e.data || zero !== e.zero || lat != e.lat) begin
            n_fail++;
            $display("FAIL %s: got data=%h zero=%b lat=%0d, need data=%h zero=%b lat=%0d",
                     e.name, dout, zero, lat, e.data, e.zero, e.lat);
        end
    endtask

    task automatic test_simple();
        logic [2:0]   ops[] = '{3'b001, 3'b001, 3'b011, 3'b010, 3'b000};
        logic [W-1:0] as[]  = '{32'd5, 32'd0, 32'hF0F0_F0F0, 32'hFF00_FF00,
                                32'hFFFF_FFFF};
        logic [W-1:0] bs[]  = '{32'd5, 32'd1, 32'h0F0F_0F0F, 32'h0FF0_0FF0, 32'd1};
        push_exp("sub_5_5", 32'd0, 1);
        push_exp("sub_0_1", 32'hFFFF_FFFF, 1);
        push_exp("or_f0_0f", 32'hFFFF_FFFF, 1);
        push_exp("and", 32'h0F00_0F00, 1);
        push_exp("add_wrap", 32'd0, 1);
        run_table(ops, as, bs);
    endtask

    task automatic test_mul();
        logic [63:0]  p = 64'd123 * 64'd456;
        logic [2:0]   ops[] = '{3'b101, 3'b101, 3'b101};
        logic [W-1:0] as[]  = '{32'h0001_0000, 32'hFFFF_FFFF, 32'd123};
        logic [W-1:0] bs[]  = '{32'h0001_0000, 32'hFFFF_FFFF, 32'd456};
        push_exp("mul_2p16_sq", 32'd0, 33);
        push_exp("mul_ones", 32'h0000_0001, 33);
        push_exp("mul_123_456", p[W-1:0], 33);
        run_table(ops, as, bs);
    endtask

    task automatic test_div();
        logic [2:0]   ops[] = '{3'b110, 3'b111, 3'b110, 3'b110, 3'b111, 3'b111};
        logic [W-1:0] as[]  = '{32'd100, 32'd100, 32'hFFFF_FFFF, 32'd9, 32'd9,
                                32'hDEAD_BEEF};
        logic [W-1:0] bs[]  = '{32'd7, 32'd7, 32'd1, 32'd0, 32'd0, 32'h0001_2345};
        push_exp("divu_100_7", 32'd100 / 32'd7, 33);
        push_exp("remu_100_7", 32'd100 % 32'd7, 33);
        push_exp("divu_max_1", 32'hFFFF_FFFF, 33);
        push_exp("divu_by0", 32'hFFFF_FFFF, 33);
        push_exp("remu_by0", 32'd9, 33);
        push_exp("remu_big", 32'hDEAD_BEEF % 32'h0001_2345, 33);
        run_table(ops, as, bs);
    endtask

    task automatic test_handshake();
        int pulses = 0;
        int busy_bad = 0;
        int cyc = 0;
        exp_t e;
        push_exp("hs_mul_3_4", 32'd12, 33);
        push_exp("hs_add_next", 32'd3, 1);
        @(negedge clk);
        op = 3'b101;
        d1 = 32'd3;
        d2 = 32'd4;
        start = 1'b1;
        @(posedge clk);
        forever begin
            @(negedge clk);
            cyc++;
            if (busy !== 1'b1) busy_bad++;
            if (valid) begin
                pulses++;
                break;
            end
            if (cyc >= 100) break;
            op = 3'($urandom);
            d1 = $urandom;
            d2 = $urandom;
        end
        e = sb.pop_front();
        n_checks++;
        if (dout !== e.data || zero !== e.zero || cyc != e.lat) begin
            n_fail++;
            $display("FAIL %s: got data=%h zero=%b lat=%0d, need data=%h zero=%b lat=%0d",
                     e.name, dout, zero, cyc, e.data, e.zero, e.lat);
        end
        n_checks++;
        if (busy_bad != 0) begin
            n_fail++;
            $display("FAIL hs_busy: got %0d cycles with busy low, need 0", busy_bad);
        end
        op = 3'b000;
        d1 = 32'd1;
        d2 = 32'd2;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || dout !== 32'd12) begin
            n_fail++;
            $display("FAIL hs_done_ignores_start: got busy=%b valid=%b data=%h, need 0 0 0000000c",
                     busy, valid, dout);
        end
        @(negedge clk);
        start = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (valid !== 1'b1 || dout !== e.data || zero !== e.zero || pulses != 1) begin
            n_fail++;
            $display("FAIL %s: got valid=%b data=%h zero=%b pulses=%0d, need 1 %h %b 1",
                     e.name, valid, dout, zero, pulses, e.data, e.zero);
        end
    endtask

    task automatic test_reserved();
        logic [2:0]   ops[] = '{3'b100, 3'b000};
        logic [W-1:0] as[]  = '{32'd9, 32'd9};
        logic [W-1:0] bs[]  = '{32'd9, 32'd9};
        push_exp("op100", 32'd0, 1);
        push_exp("add_after_op100", 32'd18, 1);
        run_table(ops, as, bs);
    endtask

    task automatic test_back_to_back();
        logic [2:0]   ops[] = '{3'b101, 3'b010, 3'b110, 3'b001};
        logic [W-1:0] as[]  = '{32'h1234_5678, 32'hAAAA_5555, 32'h8000_0000, 32'd10};
        logic [W-1:0] bs[]  = '{32'd16, 32'hFFFF_0000, 32'd3, 32'd3};
        push_exp("b2b_mul", 32'h2345_6780, 33);
        push_exp("b2b_and", 32'hAAAA_0000, 1);
        push_exp("b2b_divu", 32'h8000_0000 / 32'd3, 33);
        push_exp("b2b_sub", 32'd7, 1);
        run_table(ops, as, bs);
    endtask

    initial begin
        test_reset();
        test_reset_mid_mul();
        test_simple();
        test_mul();
        test_div();
        test_handshake();
        test_reserved();
        test_back_to_back();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d left, need 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iter_alu_unit.md
Name: iter_alu_unit

Overview:
- Multi-cycle execute-stage responder with a start/busy/valid handshake. The pipeline issues an operation and the unit answers with a registered result.
- Consumes the same 3-bit ALUCtrl encoding as the combinational ALU. Adds iterative multiply and unsigned divide/remainder.
- Lets the combinational 32x32 multiplier leave the critical path. The hazard unit stalls on busy_o.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  asynchronous, active-low reset
start_i  input  1  request strobe; sampled only in IDLE
ALUCtrl_i  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 reserved, 101 MUL, 110 DIVU, 111 REMU
data1_i  input  WIDTH  operand A (dividend, multiplicand)
data2_i  input  WIDTH  operand B (divisor, multiplier)
busy_o  output  1  high whenever state is not IDLE
valid_o  output  1  one-cycle pulse: data_o/Zero_o carry a new result
data_o  output  WIDTH  registered result; holds until the next valid_o
Zero_o  output  1  registered; 1 iff the result written with valid_o is 0

Behaviour:
- Reset (rst_i low, any time, asynchronous):
  - state IDLE; counter, operand and accumulator registers 0.
  - busy_o=0, valid_o=0, data_o=0, Zero_o=0.
  - Reset mid-operation aborts with no valid_o.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_i=1 latches ALUCtrl_i, data1_i, data2_i at the edge.
  - Opcodes 0xx and 100 go to DONE. Result computed combinationally from the latched operands and registered on entry to DONE.
  - Opcodes 101/110/111 go to RUN with counter=0.
  - start_i=0: remain IDLE.
- RUN: one iteration per cycle; counter increments; after iteration WIDTH-1 go to DONE and register the result.
- DONE: valid_o=1 for exactly this cycle, then IDLE. start_i in DONE is ignored; the issuer must re-assert it in IDLE.
- Latency from accept edge to valid_o cycle:
  - Simple ops: 1 cycle.
  - MUL/DIVU/REMU: WIDTH+1 cycles (33 by default).
- Throughput: at most one request every 2 cycles (simple) or WIDTH+2 cycles (iterative).
- start_i while busy_o=1 is ignored; latched operands are unaffected by input changes.
- Arithmetic:
  - ADD/SUB are modulo 2^WIDTH with no overflow flag.
  - Opcode 100 yields data_o=0, Zero_o=1.
- MUL: shift-add. Each iteration adds the shifted multiplicand if the current multiplier LSB is 1. data_o is the low WIDTH bits of the product; signed and unsigned agree.
- DIVU/REMU: restoring division, one quotient bit per iteration, MSB first. DIVU returns the quotient; REMU returns the remainder.
- Divide by zero (no trap):
  - DIVU returns all-ones.
  - REMU returns the dividend.
  - Still takes WIDTH+1 cycles.
- data_o/Zero_o update only on entry to DONE; they are stable at all other times.

Test Plan:
- Reset mid-MUL: rst_i low at cycle 10 of MUL 7*6 -> busy_o=0, valid_o never pulses, data_o=0. After release, ADD 5+3 -> valid_o 1 cycle later, data_o=8, Zero_o=0.
- SUB 5-5 -> data_o=0, Zero_o=1, latency 1. SUB 0-1 -> 0xFFFFFFFF, Zero_o=0. OR 0xF0F0F0F0|0x0F0F0F0F -> 0xFFFFFFFF.
- MUL 0x0001_0000*0x0001_0000 -> valid_o exactly 33 cycles after accept, data_o=0, Zero_o=1. MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001. MUL 123*456 -> 56088.
- DIVU 100/7 -> 14. REMU 100/7 -> 2. DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF. DIVU 9/0 -> 0xFFFFFFFF. REMU 9/0 -> 9.
- Handshake during MUL 3*4:
  - Hold start_i=1 and change operands and opcode throughout -> result 12, single valid_o pulse.
  - start_i held into DONE is not accepted; a new request is accepted only on the following IDLE cycle.
  - busy_o=1 from the cycle after accept through the DONE cycle.
- Opcode 100 with data1=9, data2=9 -> data_o=0, Zero_o=1, latency 1. The next request gets normal results.
